pdm_mic_decim: RTL

PDM_MIC_DECIM -- requirements
Module: pdm_mic_decim

---
 rtl/pdm_pkg.sv | 19 +
 rtl/pdm_clk_gen.sv | 54 +++++
 rtl/pdm_mic_decim.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared constants for the PDM microphone decimator: channel encoding,
// output-handshake states and the accumulator width helper.
package pdm_pkg;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_SEND_L,
    OUT_SEND_R
  } out_state_e;

  // Width of a ones-counter that must hold the value DECIM itself.
  function automatic int acc_width(input int decim);
    return $clog2(decim + 1);
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit-clock divider: mclk runs at clk/CLK_DIV while enabled; fall_stb and
// rise_stb flag the clk cycle in which mclk is about to toggle 1->0 / 0->1.
module pdm_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic mclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mclk_q, mclk_d;
  logic          tc;

  assign tc       = enable && (cnt_q == CW'(HALF - 1));
  assign fall_stb = tc && mclk_q;
  assign rise_stb = tc && !mclk_q;
  assign mclk     = mclk_q;

  // NOTE: every next-state signal gets its hold value first, so no path
  // through this block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    mclk_d = mclk_q;
    if (!enable) begin
      cnt_d  = '0;
      mclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      mclk_d = ~mclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= mclk_d;
    end
  end

endmodule

// File: rtl/pdm_mic_decim.sv
// PDM microphone decimator: ones-count per channel over DECIM bits, PCM
// output with valid/ready handshake. Optional amp monitor: PDM_PWM_MONITOR_EN.
module pdm_mic_decim
  import pdm_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int DECIM    = 64,
  parameter int CHANNELS = 1,
  parameter int OUT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             micData,
  output logic             mclk,
  output logic             micLRSel,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_ch,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             ovf,
  output logic             ampPWM,
  output logic             ampSD
);

  localparam int AW     = acc_width(DECIM);
  localparam int BW     = $clog2(DECIM);
  localparam bit STEREO = (CHANNELS == 2);

  logic fall_stb, rise_stb;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mclk     (mclk),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  logic          pair_q, pair_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [AW-1:0] sum_l, sum_r;
  logic          l_stb, r_stb, last_stb, frame_done;

  // An R bit only counts once its L partner has been taken, so a frame is
  // always DECIM complete (L, R) pairs even though mclk rises first.
  assign l_stb      = fall_stb;
  assign r_stb      = STEREO && rise_stb && pair_q;
  assign last_stb   = STEREO ? r_stb : l_stb;
  assign frame_done = last_stb && (bit_cnt_q == BW'(DECIM - 1));
  assign sum_l      = acc_l_q + AW'(l_stb && micData);
  assign sum_r      = acc_r_q + AW'(r_stb && micData);

  function automatic logic [OUT_W-1:0] to_pcm(input logic [AW-1:0] c);
    return (OUT_W'(c) << 1) - OUT_W'(DECIM);
  endfunction

  always_comb begin
    pair_d    = pair_q;
    bit_cnt_d = bit_cnt_q;
    acc_l_d   = sum_l;
    acc_r_d   = sum_r;
    if (!enable) begin
      pair_d    = 1'b0;
      bit_cnt_d = '0;
      acc_l_d   = '0;
      acc_r_d   = '0;
    end else begin
      if (l_stb)         pair_d = 1'b1;
      else if (rise_stb) pair_d = 1'b0;
      if (frame_done) begin
        bit_cnt_d = '0;
        acc_l_d   = '0;
        acc_r_d   = '0;
      end else if (last_stb) begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
  end

  out_state_e       state_q, state_d;
  logic [OUT_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic             ovf_q, ovf_d;

  // A frame finishing in the same cycle as the last pending acceptance is
  // taken, since the buffer frees up at that very edge.
  always_comb begin
    state_d = state_q;
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    ovf_d   = ovf_q;
    case (state_q)
      OUT_SEND_L: if (pcm_ready) state_d = STEREO ? OUT_SEND_R : OUT_IDLE;
      OUT_SEND_R: if (pcm_ready) state_d = OUT_IDLE;
      default:    ;
    endcase
    if (frame_done) begin
      if (state_d == OUT_IDLE) begin
        state_d = OUT_SEND_L;
        buf_l_d = to_pcm(sum_l);
        buf_r_d = to_pcm(sum_r);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: the sample buffers are reset too, because pcm_data must read 0
  // straight out of reset rather than whatever the flops powered up with.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_q    <= 1'b0;
      bit_cnt_q <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      state_q   <= OUT_IDLE;
      buf_l_q   <= '0;
      buf_r_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      bit_cnt_q <= bit_cnt_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      state_q   <= state_d;
      buf_l_q   <= buf_l_d;
      buf_r_q   <= buf_r_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pcm_valid = (state_q != OUT_IDLE);
  assign pcm_ch    = (state_q == OUT_SEND_R) ? CH_R : CH_L;
  assign pcm_data  = (state_q == OUT_SEND_R) ? buf_r_q : buf_l_q;
  assign ovf       = ovf_q;
  assign micLRSel  = 1'b0;

`ifdef PDM_PWM_MONITOR_EN
  logic amp_pwm_q, amp_sd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      amp_pwm_q <= 1'b0;
      amp_sd_q  <= 1'b0;
    end else begin
      if (l_stb) amp_pwm_q <= micData;
      amp_sd_q <= enable;
    end
  end

  assign ampPWM = amp_pwm_q;
  assign ampSD  = amp_sd_q;
`else
  assign ampPWM = 1'b0;
  assign ampSD  = 1'b0;
`endif

endmodule
